// File: rtl/rx_ring_pkg.sv
// rx_ring_pkg: shared defaults and width rules for the rx_ring_fifo slice.
package rx_ring_pkg;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 48;
  localparam int DEF_BYTE_SIZE = 8;
  localparam int DEF_AFULL_THRESH = 28;
  localparam int OVF_WIDTH = 8;
  function automatic int be_width(input int data_width, input int byte_size);
    return data_width / byte_size;
  endfunction
  // one extra bit so a completely full ring (DEPTH) is representable
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction
endpackage

// File: rtl/rx_ring_ram.sv
// rx_ring_ram: ring storage, one byte-enabled write port and one registered read port.
module rx_ring_ram
  import rx_ring_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTE_SIZE = DEF_BYTE_SIZE,
  localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (we_i)
      for (int b = 0; b < BE_WIDTH; b++)
        if (be_i[b]) mem_q[waddr_i][b*BYTE_SIZE +: BYTE_SIZE] <= wdata_i[b*BYTE_SIZE +: BYTE_SIZE];
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/rx_ring_fifo.sv
// rx_ring_fifo: first-word-fall-through ring FIFO with byte-enabled writes and flush.
// Define RX_RING_FIFO_STATS_EN to build the overflow counter and occupancy peak tracker.
module rx_ring_fifo
  import rx_ring_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTE_SIZE = DEF_BYTE_SIZE,
  parameter int AFULL_THRESH = DEF_AFULL_THRESH,
  localparam int BE_WIDTH = be_width(DATA_WIDTH, BYTE_SIZE),
  localparam int CNT_W = cnt_width(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_byte_en,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  flush,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full,
  output logic [OVF_WIDTH-1:0]  overflow_cnt,
  output logic [CNT_W-1:0]      peak_count
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d, unread;
  logic mid_vld_q, mid_vld_d, out_vld_q, out_vld_d;
  logic wr_ready_q, afull_q;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, ram_rdata;
  logic push, pop, load, issue;
  // Two-stage prefetch: RAM read register (mid) feeds the output register (out),
  // so a read can be issued every cycle the pair keeps draining.
  always_comb begin
    push = wr_valid && wr_ready_q && !flush;
    pop = out_vld_q && rd_ready && !flush;
    unread = count_q - CNT_W'(mid_vld_q) - CNT_W'(out_vld_q);
    load = mid_vld_q && (!out_vld_q || pop);
    issue = !flush && unread != '0 && (!mid_vld_q || load);
    wptr_d = flush ? '0 : wptr_q + ADDR_WIDTH'(push);
    rptr_d = flush ? '0 : rptr_q + ADDR_WIDTH'(issue);
    count_d = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    mid_vld_d = !flush && (issue || (mid_vld_q && !load));
    out_vld_d = !flush && (load || (out_vld_q && !pop));
    rd_data_d = load ? ram_rdata : rd_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      mid_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      wr_ready_q <= 1'b0;
      afull_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      mid_vld_q <= mid_vld_d;
      out_vld_q <= out_vld_d;
      wr_ready_q <= count_d != CNT_W'(DEPTH);
      afull_q <= count_d >= CNT_W'(AFULL_THRESH);
      rd_data_q <= rd_data_d;
    end
  end
  rx_ring_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .BYTE_SIZE(BYTE_SIZE)
  ) u_ram (
    .clk_i(clk),
    .we_i(push),
    .waddr_i(wptr_q),
    .wdata_i(wr_data),
    .be_i(wr_byte_en),
    .re_i(issue),
    .raddr_i(rptr_q),
    .rdata_o(ram_rdata)
  );
  assign wr_ready = wr_ready_q;
  assign rd_valid = out_vld_q;
  assign rd_data = rd_data_q;
  assign count = count_q;
  assign almost_full = afull_q;
`ifdef RX_RING_FIFO_STATS_EN
  logic [OVF_WIDTH-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0] peak_q, peak_d;
  always_comb begin
    ovf_d = (wr_valid && !wr_ready_q && ovf_q != '1) ? ovf_q + 1'b1 : ovf_q;
    peak_d = count_d > peak_q ? count_d : peak_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
      peak_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      peak_q <= peak_d;
    end
  end
  assign overflow_cnt = ovf_q;
  assign peak_count = peak_q;
`else
  assign overflow_cnt = '0;
  assign peak_count = '0;
`endif
endmodule
